// File: rtl/sc_regwrite_pkg.sv
// Shared definitions for the register-write sequencer: sequencer FSM states
// and the default parameter values used by the register-bank blocks.
package sc_regwrite_pkg;

  localparam int DEF_DATAWIDTH_BUS = 32;
  localparam int DEF_NUMREG        = 8;
  localparam int DEF_ADDRWIDTH     = 3;
  localparam int DEF_FIFO_DEPTH    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/sc_regwrite_fifo.sv
// Pending-request FIFO for the register-write sequencer: wrap-around pointers,
// registered occupancy and registered full/empty/ready flags.
module sc_regwrite_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4,
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNTW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             ready,
  output logic             full,
  output logic             empty,
  output logic [CNTW-1:0]  count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             ready_q, ready_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // Flags are recomputed from the next occupancy so they come straight from flops.
  always_comb begin
    do_push  = push && ready_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTRW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTRW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
    ready_d = (count_d != CNTW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign ready = ready_q;
  assign full  = !ready_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/sc_regwrite_sequencer.sv
// Queues register write requests and replays each one as a SETUP cycle
// (data on the bus) followed by a one-cycle active-low strobe to one register.
module sc_regwrite_sequencer
  import sc_regwrite_pkg::*;
#(
  parameter int DATAWIDTH_BUS = DEF_DATAWIDTH_BUS,
  parameter int NUMREG        = DEF_NUMREG,
  parameter int ADDRWIDTH     = DEF_ADDRWIDTH,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
  input  logic                     SC_RegWRITESEQ_CLOCK_50,
  input  logic                     SC_RegWRITESEQ_RESET_InHigh,
  input  logic                     SC_RegWRITESEQ_Req_Valid_InHigh,
  input  logic [ADDRWIDTH-1:0]     SC_RegWRITESEQ_Req_Addr_In,
  input  logic [DATAWIDTH_BUS-1:0] SC_RegWRITESEQ_Req_Data_In,
  output logic                     SC_RegWRITESEQ_Req_Ready_OutHigh,
  output logic [NUMREG-1:0]        SC_RegWRITESEQ_Write_OutLow,
  output logic [DATAWIDTH_BUS-1:0] SC_RegWRITESEQ_DataBUS_Out,
  output logic                     SC_RegWRITESEQ_Done_OutHigh,
  output logic                     SC_RegWRITESEQ_Error_OutHigh,
  output logic                     SC_RegWRITESEQ_Busy_OutHigh
);

  localparam int EW   = ADDRWIDTH + DATAWIDTH_BUS;
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);

  logic clk, rst;
  assign clk = SC_RegWRITESEQ_CLOCK_50;
  assign rst = SC_RegWRITESEQ_RESET_InHigh;

  logic                     fifo_push, fifo_pop;
  logic                     fifo_ready, fifo_full, fifo_empty;
  logic [CNTW-1:0]          fifo_count;
  logic [EW-1:0]            fifo_head;
  logic [ADDRWIDTH-1:0]     head_addr;
  logic [DATAWIDTH_BUS-1:0] head_data;

  assign fifo_push              = SC_RegWRITESEQ_Req_Valid_InHigh && !fifo_full;
  assign {head_addr, head_data} = fifo_head;

  sc_regwrite_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({SC_RegWRITESEQ_Req_Addr_In, SC_RegWRITESEQ_Req_Data_In}),
    .rdata (fifo_head),
    .ready (fifo_ready),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  seq_state_e               state_q, state_d;
  logic [ADDRWIDTH-1:0]     addr_q, addr_d;
  logic [DATAWIDTH_BUS-1:0] data_q, data_d;
  logic [NUMREG-1:0]        write_n_q, write_n_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic                     busy_q, busy_d;

  // IDLE and STROBE both launch the next request, which gives back-to-back
  // writes every second cycle while the queue stays non-empty.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    write_n_d = '1;
    done_d    = 1'b0;
    error_d   = 1'b0;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE, ST_STROBE: begin
        if (!fifo_empty) begin
          state_d  = ST_SETUP;
          fifo_pop = 1'b1;
          addr_d   = head_addr;
          data_d   = head_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        done_d  = 1'b1;
        error_d = (int'(addr_q) >= NUMREG);
        for (int i = 0; i < NUMREG; i++) begin
          if (int'(addr_q) == i) begin
            write_n_d[i] = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Busy reflects the occupancy and state that will hold after this edge.
    busy_d = (state_d != ST_IDLE) || fifo_push ||
             (fifo_count > CNTW'(1)) ||
             ((fifo_count == CNTW'(1)) && !fifo_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      write_n_q <= '1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      write_n_q <= write_n_d;
      done_q    <= done_d;
      error_q   <= error_d;
      busy_q    <= busy_d;
    end
  end

  assign SC_RegWRITESEQ_Req_Ready_OutHigh = fifo_ready;
  assign SC_RegWRITESEQ_Write_OutLow      = write_n_q;
  assign SC_RegWRITESEQ_DataBUS_Out       = data_q;
  assign SC_RegWRITESEQ_Done_OutHigh      = done_q;
  assign SC_RegWRITESEQ_Error_OutHigh     = error_q;
  assign SC_RegWRITESEQ_Busy_OutHigh      = busy_q;

endmodule
